// File: rtl/mbc_pkg.sv
// Shared types and constants for the multibroadcast sequencing controller.
// The optional even-parity path is enabled with MBC_PARITY_EN.
package mbc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAR,
      PAYLOAD,
      DROP,
      DONE
   } mbcState_e;

   localparam int MBC_NPORT  = 4;
   localparam int MBC_LINE_W = 2;

   // Header is mask, then line, then length, all LSB first.
   function automatic int hdr_w(input int lenW);
      return MBC_NPORT + MBC_LINE_W + lenW;
   endfunction

endpackage

// File: rtl/mbc_hdr_shift.sv
// LSB-first serial-in header shift register with a load counter.
// Exposes a parity output only when MBC_PARITY_EN is defined.
module mbc_hdr_shift
   import mbc_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  shiftEn_i,
   input  logic                  bit_i,
`ifdef MBC_PARITY_EN
   output logic                  parity_o,
`endif
   output logic [MBC_NPORT-1:0]  mask_o,
   output logic [MBC_LINE_W-1:0] line_o,
   output logic [LEN_W-1:0]      lenNext_o,
   output logic                  hdrFull_o
);

   localparam int HW = hdr_w(LEN_W);
   localparam int CW = $clog2(HW);
   localparam logic [CW-1:0] LAST = CW'(HW - 1);

   logic [HW-1:0] hdr_q, hdr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // New bits enter at the MSB so the first received bit ends up at bit 0.
   always_comb begin
      hdr_d = hdr_q;
      cnt_d = cnt_q;
      if (shiftEn_i) begin
         hdr_d = {bit_i, hdr_q[HW-1:1]};
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hdr_q <= '0;
         cnt_q <= '0;
      end else begin
         hdr_q <= hdr_d;
         cnt_q <= cnt_d;
      end
   end

   assign hdrFull_o = shiftEn_i && (cnt_q == LAST);
   assign mask_o    = hdr_q[MBC_NPORT-1:0];
   assign line_o    = hdr_q[MBC_NPORT +: MBC_LINE_W];
   // Length as it will be once the bit being sampled now is shifted in.
   assign lenNext_o = hdr_d[MBC_NPORT + MBC_LINE_W +: LEN_W];

`ifdef MBC_PARITY_EN
   assign parity_o = ^hdr_q;
`endif

endmodule

// File: rtl/multibroadcast_ctrl.sv
// Sequencing controller in front of the 1-to-16 serial multibroadcast demux.
// Define MBC_PARITY_EN to add the even-parity check with PAR/DROP states and err_o.
module multibroadcast_ctrl
   import mbc_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  serIn_i,
   output logic                  serOut_o,
   output logic [MBC_NPORT-1:0]  PB_o,
   output logic [MBC_LINE_W-1:0] LB_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   mbcState_e state_q, state_d;

   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic                  serOut_q, serOut_d;
   logic [MBC_NPORT-1:0]  pb_q, pb_d;
   logic [MBC_LINE_W-1:0] lb_q, lb_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [MBC_NPORT-1:0]  mask;
   logic [MBC_LINE_W-1:0] line;
   logic [LEN_W-1:0]      lenNext;
   logic                  hdrFull;

`ifdef MBC_PARITY_EN
   logic hdrParity;
   logic parityBad;
   logic err_q, err_d;

   assign parityBad = serIn_i != hdrParity;
`endif

   mbc_hdr_shift #(
      .LEN_W(LEN_W)
   ) u_hdr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .shiftEn_i(state_q == HDR),
      .bit_i    (serIn_i),
`ifdef MBC_PARITY_EN
      .parity_o (hdrParity),
`endif
      .mask_o   (mask),
      .line_o   (line),
      .lenNext_o(lenNext),
      .hdrFull_o(hdrFull)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         serOut_q <= 1'b0;
         pb_q     <= '0;
         lb_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MBC_PARITY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         serOut_q <= serOut_d;
         pb_q     <= pb_d;
         lb_q     <= lb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MBC_PARITY_EN
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!serIn_i) state_d = HDR;
         HDR: begin
            if (hdrFull) begin
`ifdef MBC_PARITY_EN
               state_d = PAR;
`else
               state_d = (lenNext != '0) ? PAYLOAD : DONE;
`endif
            end
         end
`ifdef MBC_PARITY_EN
         PAR: begin
            if (cnt_q == '0)    state_d = DONE;
            else if (parityBad) state_d = DROP;
            else                state_d = PAYLOAD;
         end
         PAYLOAD, DROP: if (cnt_q == LEN_W'(1)) state_d = DONE;
`else
         PAYLOAD: if (cnt_q == LEN_W'(1)) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output registers are loaded on the same edge that samples the bit.
   always_comb begin
      cnt_d    = cnt_q;
      serOut_d = serOut_q;
      pb_d     = pb_q;
      lb_d     = lb_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef MBC_PARITY_EN
      err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: if (!serIn_i) busy_d = 1'b1;
         HDR:  if (hdrFull) cnt_d = lenNext;
         PAYLOAD: begin
            serOut_d = serIn_i;
            pb_d     = mask;
            lb_d     = line;
            cnt_d    = cnt_q - 1'b1;
         end
`ifdef MBC_PARITY_EN
         PAR:  err_d = parityBad;
         DROP: begin
            serOut_d = 1'b0;
            pb_d     = '0;
            cnt_d    = cnt_q - 1'b1;
         end
`endif
         DONE: begin
            serOut_d = 1'b0;
            pb_d     = '0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: ;
      endcase
   end

   assign serOut_o = serOut_q;
   assign PB_o     = pb_q;
   assign LB_o     = lb_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
`ifdef MBC_PARITY_EN
   assign err_o    = err_q;
`else
   assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_multibroadcast_ctrl.sv
// Scoreboard bench for multibroadcast_ctrl: frames are queued with their expected
// outcome when sent, and a negedge monitor checks each payload window and done pulse.
module tb_multibroadcast_ctrl;

   localparam int LEN_W = 4;
   localparam int HW    = 4 + 2 + LEN_W;
`ifdef MBC_PARITY_EN
   localparam int PARB  = 1;
`else
   localparam int PARB  = 0;
`endif

   typedef struct {
      int       mask;
      int       line;
      int       len;
      int       bits;
      int       winStart;
      int       doneCyc;
      bit       errExp;
      int       errCyc;
      int       lbExp;
   } exp_t;

   logic       clk_i;
   logic       rst_i;
   logic       serIn_i;
   logic       serOut_o;
   logic [3:0] PB_o;
   logic [1:0] LB_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   int   checks;
   int   failures;
   int   cyc;
   int   lbModel;
   exp_t expQ[$];
   bit   frameQ[$];

   int          curCount;
   int          errSeen;
   logic [15:0] curBits;
   exp_t        monExp;

   multibroadcast_ctrl #(
      .LEN_W(LEN_W)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .serIn_i (serIn_i),
      .serOut_o(serOut_o),
      .PB_o    (PB_o),
      .LB_o    (LB_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Edge counter: after edge n, every sampler sees cyc == n.
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic driveBit(input bit b);
      serIn_i = b;
      @(posedge clk_i);
      #1;
   endtask

   // Builds a frame, queues its expected outcome and drives it (optionally only the
   // first stopAt bits). Called #1 after a rising edge, so the start bit lands on cyc+1.
   task automatic applyStimulus(input logic [3:0] mask, input logic [1:0] line,
                                input logic [3:0] len, input logic [15:0] bits,
                                input int gap, input bit badIn, input int stopAt);
      exp_t e;
      int   s;
      bit   bad;
      int   nBits;
      bad = badIn;
      if (PARB == 0) bad = 1'b0;
      s = cyc + 1;
      e.mask     = int'(mask);
      e.line     = int'(line);
      e.len      = int'(len);
      e.bits     = int'(bits);
      e.winStart = s + HW + PARB + 1;
      e.doneCyc  = s + HW + PARB + int'(len) + 1;
      e.errExp   = bad;
      e.errCyc   = s + HW + 1;
      e.lbExp    = (!bad && len != 0) ? int'(line) : lbModel;
      lbModel    = e.lbExp;
      expQ.push_back(e);

      frameQ.delete();
      frameQ.push_back(1'b0);
      for (int i = 0; i < 4; i++) frameQ.push_back(mask[i]);
      for (int i = 0; i < 2; i++) frameQ.push_back(line[i]);
      for (int i = 0; i < LEN_W; i++) frameQ.push_back(len[i]);
      if (PARB != 0) frameQ.push_back((^{len, line, mask}) ^ bad);
      for (int i = 0; i < int'(len); i++) frameQ.push_back(bits[i]);

      nBits = (stopAt >= 0) ? stopAt : frameQ.size();
      for (int i = 0; i < nBits; i++) driveBit(frameQ[i]);
      if (stopAt < 0) begin
         for (int i = 0; i < gap; i++) driveBit(1'b1);
      end
   endtask

   // Monitor: payload window cycles are checked against the front entry, which is
   // retired on its done pulse.
   always @(negedge clk_i) begin
      if (rst_i) begin
         curCount = 0;
         errSeen  = 0;
         curBits  = '0;
      end else begin
         if (err_o) begin
            errSeen++;
            if (expQ.size() == 0 || !expQ[0].errExp) reportFail("unexpectedErr");
            else checkOutput("errCycle", cyc, expQ[0].errCyc);
         end
         if (PB_o != 4'd0) begin
            if (expQ.size() == 0) reportFail("pbWithoutPacket");
            else begin
               checkOutput("pbMask", int'(PB_o), expQ[0].mask);
               checkOutput("lbWindow", int'(LB_o), expQ[0].line);
               checkOutput("windowCycle", cyc, expQ[0].winStart + curCount);
               if (curCount < 16) curBits[curCount] = serOut_o;
               curCount++;
            end
         end
         if (done_o) begin
            if (expQ.size() == 0) reportFail("unexpectedDone");
            else begin
               int expLen;
               int lenMask;
               monExp  = expQ.pop_front();
               expLen  = (monExp.mask != 0 && !monExp.errExp) ? monExp.len : 0;
               lenMask = (1 << monExp.len) - 1;
               checkOutput("doneCycle", cyc, monExp.doneCyc);
               checkOutput("pbAtDone", int'(PB_o), 0);
               checkOutput("busyAtDone", int'(busy_o), 0);
               checkOutput("lbAtDone", int'(LB_o), monExp.lbExp);
               checkOutput("errCount", errSeen, int'(monExp.errExp));
               checkOutput("windowLen", curCount, expLen);
               if (expLen > 0)
                  checkOutput("payloadBits", int'(curBits) & lenMask, monExp.bits & lenMask);
            end
            curCount = 0;
            errSeen  = 0;
            curBits  = '0;
         end
      end
   end

   initial begin
      int nz;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      lbModel  = 0;
      curCount = 0;
      errSeen  = 0;
      curBits  = '0;
      rst_i    = 1'b1;
      serIn_i  = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      checkOutput("rstSerOut", int'(serOut_o), 0);
      checkOutput("rstPB", int'(PB_o), 0);
      checkOutput("rstLB", int'(LB_o), 0);
      checkOutput("rstBusy", int'(busy_o), 0);
      checkOutput("rstDone", int'(done_o), 0);
      checkOutput("rstErr", int'(err_o), 0);

      nz = 0;
      repeat (50) begin
         @(negedge clk_i);
         if (busy_o || PB_o != 4'd0 || done_o) nz++;
      end
      checkOutput("idleQuiet", nz, 0);
      @(posedge clk_i);
      #1;

      $display("[TB] directed packets");
      applyStimulus(4'b0101, 2'b10, 4'd3, 16'b101, 1, 1'b0, -1);
      applyStimulus(4'b1111, 2'b01, 4'd0, 16'h0, 2, 1'b0, -1);
      applyStimulus(4'b0011, 2'b01, 4'd2, 16'b10, 1, 1'b0, -1);
      applyStimulus(4'b1000, 2'b11, 4'd4, 16'b0110, 1, 1'b0, -1);
      applyStimulus(4'b0000, 2'b10, 4'd5, 16'b10111, 1, 1'b0, -1);
      applyStimulus(4'b1110, 2'b00, 4'd15, 16'h5A3C, 1, 1'b0, -1);
      applyStimulus(4'b0110, 2'b11, 4'd4, 16'b1011, 1, 1'b1, -1);
      applyStimulus(4'b1001, 2'b01, 4'd0, 16'h0, 1, 1'b1, -1);

      $display("[TB] reset during payload");
      applyStimulus(4'b1101, 2'b10, 4'd5, 16'b11011, 0, 1'b0, 1 + HW + PARB + 2);
      serIn_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("abortPB", int'(PB_o), 0);
      checkOutput("abortBusy", int'(busy_o), 0);
      expQ.delete();
      lbModel = 0;
      serIn_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      driveBit(1'b1);
      applyStimulus(4'b0111, 2'b01, 4'd3, 16'b011, 1, 1'b0, -1);

      $display("[TB] random packets");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
                       4'($urandom_range(15, 0)), 16'($urandom),
                       $urandom_range(3, 1), ($urandom_range(3, 0) == 0), -1);
      end

      for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk_i);
      #1;
      checkOutput("queueDrained", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multibroadcast_ctrl.md
# multibroadcast_ctrl

Sequencing controller for the 1-to-16 serial multibroadcast demux. It receives a framed serial packet on `serIn` and decodes a header carrying the port mask, line select and payload length. It then streams the payload bits to the demux with `PB`/`LB` held stable for exactly the payload window, and returns to idle. It sits directly in front of the demux: its `serOut`, `PB` and `LB` drive the demux's `serIn`, `PB` and `LB`.

## Interface
- `LEN_W`, default 4: width of the header length field. Max payload is 2^LEN_W−1 bits.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `serIn` input 1: serial line. Idle level is 1.
- `serOut` output 1: registered payload bit to the demux.
- `PB` output 4: port-group enable mask. Multiple bits allowed (broadcast). Zero outside the payload window.
- `LB` output 2: line select within the group.
- `busy` output 1: high from start-bit acceptance until the cycle after DONE.
- `done` output 1: one-cycle pulse at packet completion.
- `err` output 1: one-cycle pulse on parity failure. Tied 0 without the macro.

## Operation
- Reset values: `serOut`=0, `PB`=0, `LB`=0, `busy`=0, `done`=0, `err`=0, state IDLE, all counters 0.
- Frame format, sampled one bit per clock:
  - start bit 0
  - 4 bits mask, PB[0] first
  - 2 bits line, LB[0] first
  - LEN_W bits length, LSB first
  - [parity bit]
  - LEN payload bits
- States: IDLE → HDR → [PAR] → PAYLOAD or DROP → DONE → IDLE.
- IDLE: stays while `serIn`=1. Moves to HDR on `serIn`=0 and sets `busy`.
- HDR: shifts 6+LEN_W bits into the header register, using a bit counter from 0 to 5+LEN_W.
- After the last header bit:
  - Goes to PAR if the macro is enabled.
  - Otherwise goes to PAYLOAD if LEN≠0.
  - Otherwise goes to DONE.
- PAYLOAD: each sampled `serIn` bit is registered to `serOut`. In the same edge, `PB`←mask and `LB`←line. The payload counter decrements. When the last bit is sampled, the state moves to DONE.
- DONE:
  - `PB`←0, `serOut`←0, and `LB` holds its last value.
  - `done`=1 for one cycle.
  - `serIn` is ignored.
  - The state returns to IDLE and `busy` clears.
- Mask 0000: the packet is still consumed. `PB` stays 0 and `done` still pulses.
- No abort path exists. Only `rst` aborts mid-packet. Reset clears `PB` immediately (asynchronously), so the demux output drops at once.

## Timing
- Edge numbering: E0 samples the start bit. E1..E(6+LEN_W) sample the header. The parity bit, if present, is sampled at the next edge.
- Payload bit k sampled at edge Ep+k appears on `serOut` after that edge. `PB`/`LB` are valid in the same cycle, giving 1-cycle latency.
- `PB` is nonzero for exactly LEN consecutive cycles.
- `done` is high in the cycle after the last payload output. `PB` is already 0 in that cycle.
- Back-to-back packets: a start bit is accepted at the first edge in IDLE, i.e. 2 cycles after the last payload sample. The minimum gap is one idle-level bit, sampled during DONE.
- LEN=0: `done` is asserted in the cycle after the last header or parity bit.

## Configuration
- `MBC_PARITY_EN` defined:
  - One even-parity bit follows the header, covering mask, line and length.
  - On mismatch, the state goes to DROP. DROP consumes LEN bits with `PB`=0 and `serOut`=0, then goes to DONE.
  - `err` pulses in the cycle after the parity bit is sampled.
  - `done` still pulses at the end.
- Undefined: no PAR or DROP states, and `err` is tied 0.

## Structure
- Package `mbc_pkg` holds:
  - the state enum (`IDLE`, `HDR`, `PAR`, `PAYLOAD`, `DROP`, `DONE`)
  - `MBC_NPORT`=4
  - `MBC_LINE_W`=2
  - the header width function `hdr_w(LEN_W)`=6+LEN_W
- One sub-module, `mbc_hdr_shift`: an LSB-first serial-in shift register with a load counter. It outputs the mask, line and length fields and a `hdr_full` strobe.

## Test plan
- Idle line: `serIn`=1 for 50 cycles → `busy`, `PB`, `done` all stay 0.
- Packet start=0, mask=0101, line=10, LEN=3, payload 1,0,1 → `serOut` 1,0,1 on 3 consecutive cycles with `PB`=0101, `LB`=10. Then `PB`=0 and `done`=1 for one cycle.
- LEN=0, mask=1111 → `PB` never nonzero. `done` pulses one cycle after the last header bit.
- Two packets separated by one idle bit → both are decoded, with two `done` pulses and correct masks for each.
- `rst` asserted mid-payload (bit 2 of 5) → `PB`=0 and `busy`=0 immediately. After release, the next packet decodes normally.
- With `MBC_PARITY_EN`, wrong parity, LEN=4 → `err` pulses once, `PB` stays 0 for the 4 payload cycles, then `done` pulses.
